// File: rtl/if_id_buffer.sv
// if_id_buffer: two-entry elastic buffer between instruction fetch and decode.
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset
//   if_valid  - fetch presents {if_pc, if_instr}
//   if_pc     - fetched PC
//   if_instr  - fetched instruction
//   if_ready  - buffer can accept an entry (registered state only)
//   id_valid  - head entry valid for decode
//   id_pc     - head entry PC
//   id_instr  - head entry instruction, NOP_INSTR when empty
//   id_ready  - decode consumes head entry
//   flush     - discard all entries, overrides same-cycle enq/deq
//   occupancy - number of valid entries, 0..2
module if_id_buffer #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic [XLEN-1:0] if_instr,
    output logic            if_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr,
    input  logic            id_ready,
    input  logic            flush,
    output logic [1:0]      occupancy
);
    logic [XLEN-1:0] r_pc [2];
    logic [XLEN-1:0] r_instr [2];
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [1:0]      r_count;
    logic            w_enq;
    logic            w_deq;

    assign if_ready  = r_count != 2'd2;
    assign id_valid  = r_count != 2'd0;
    assign id_pc     = r_pc[r_rd_ptr];
    assign id_instr  = id_valid ? r_instr[r_rd_ptr] : NOP_INSTR;
    assign occupancy = r_count;
    assign w_enq     = if_valid & if_ready;
    assign w_deq     = id_valid & id_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_pc[i]    <= '0;
                r_instr[i] <= NOP_INSTR;
            end
        end else if (flush) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_enq) begin
                r_pc[r_wr_ptr]    <= if_pc;
                r_instr[r_wr_ptr] <= if_instr;
                r_wr_ptr          <= ~r_wr_ptr;
            end
            if (w_deq)
                r_rd_ptr <= ~r_rd_ptr;
            // enq and deq together cancel, leaving the count unchanged
            r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
        end
    end
endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: directed self-checking bench for if_id_buffer.
module tb_if_id_buffer;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_instr = '0;
    logic        if_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_ready = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  occupancy;
    int          n_chk = 0;
    int          n_fail = 0;

    if_id_buffer dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_ready(id_ready),
        .flush(flush), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_occ"}, 32'(occupancy), 0);
        check({tag, "_vld"}, 32'(id_valid), 0);
        check({tag, "_ins"}, id_instr, NOP);
        check({tag, "_rdy"}, 32'(if_ready), 1);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        if_valid = v;
        if_pc    = pc;
        if_instr = pc ^ 32'hA5A50000;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        check_empty("rst");
        check("rst_pc", id_pc, 0);

        // single transfer
        id_ready = 1'b1;
        if_valid = 1'b1; if_pc = 32'h0; if_instr = 32'h00500093;
        step();
        if_valid = 1'b0;
        check("one_vld", 32'(id_valid), 1);
        check("one_pc", id_pc, 32'h0);
        check("one_ins", id_instr, 32'h00500093);
        step();
        check_empty("one_drain");

        // fill and stall
        id_ready = 1'b0;
        drive(1, 32'h4); step();
        check("fill1_occ", 32'(occupancy), 1);
        drive(1, 32'h8); step();
        drive(1, 32'hC);
        check("fill2_occ", 32'(occupancy), 2);
        check("fill2_rdy", 32'(if_ready), 0);
        step();
        check("stall_occ", 32'(occupancy), 2);
        check("stall_rdy", 32'(if_ready), 0);
        check("stall_pc", id_pc, 32'h4);
        check("stall_ins", id_instr, 32'h4 ^ 32'hA5A50000);
        id_ready = 1'b1;
        step();
        check("drain1_pc", id_pc, 32'h8);
        check("drain1_occ", 32'(occupancy), 1);
        check("drain1_rdy", 32'(if_ready), 1);
        step();
        drive(0, 32'h0);
        check("drain2_pc", id_pc, 32'hC);
        check("drain2_occ", 32'(occupancy), 1);
        step();
        check_empty("drain3");

        // streaming at count=1
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h10 + 32'(4 * i));
            step();
            check("strm_pc", id_pc, 32'h10 + 32'(4 * i));
            check("strm_occ", 32'(occupancy), 1);
        end
        drive(0, 32'h0);
        step();
        check_empty("strm_end");

        // flush priority
        id_ready = 1'b0;
        drive(1, 32'h20); step();
        drive(1, 32'h24); step();
        check("fl_full", 32'(occupancy), 2);
        drive(1, 32'h28);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(0, 32'h0);
        check_empty("fl");
        step();
        check_empty("fl_hold");
        drive(1, 32'h100); step();
        drive(0, 32'h0);
        check("fl_new_pc", id_pc, 32'h100);
        check("fl_new_ins", id_instr, 32'h100 ^ 32'hA5A50000);
        check("fl_new_occ", 32'(occupancy), 1);
        id_ready = 1'b1;
        step();
        check_empty("fl_drain");

        // flush with a simultaneous dequeue
        id_ready = 1'b0;
        drive(1, 32'h30); step();
        drive(0, 32'h0);
        id_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_empty("fl_deq");

        // asynchronous reset mid-stream
        id_ready = 1'b0;
        drive(1, 32'h200); step();
        drive(1, 32'h204); step();
        drive(0, 32'h0);
        check("ar_full", 32'(occupancy), 2);
        #2 rst = 1'b0;
        #1;
        check_empty("ar_async");
        check("ar_pc", id_pc, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check_empty("ar_rel");

        // empty dequeue
        id_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("edq_occ", 32'(occupancy), 0);
            check("edq_vld", 32'(id_valid), 0);
        end
        id_ready = 1'b0;
        drive(1, 32'h300); step();
        drive(1, 32'h304); step();
        drive(0, 32'h0);
        check("edq_pc0", id_pc, 32'h300);
        check("edq_occ2", 32'(occupancy), 2);
        id_ready = 1'b1;
        step();
        check("edq_pc1", id_pc, 32'h304);
        check("edq_ins1", id_instr, 32'h304 ^ 32'hA5A50000);
        step();
        check_empty("edq_end");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Two-entry elastic buffer between the instruction fetch stage and the decode stage.
- Captures each fetched {PC, instruction} pair under a valid/ready handshake and presents entries to decode in order.
- Absorbs decode stalls without a combinational ready path back into fetch.
- Supports a synchronous flush, driven by taken branches resolved downstream.

Parameters:
- XLEN, 32, width of PC and instruction words.
- NOP_INSTR, 32'h00000013, instruction value presented on id_instr when the buffer is empty or reset.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-low reset.
- if_valid  input  1  fetch stage presents a valid {if_pc, if_instr}.
- if_pc  input  XLEN  PC of the fetched instruction.
- if_instr  input  XLEN  fetched instruction word.
- if_ready  output  1  buffer can accept an entry this cycle.
- id_valid  output  1  head entry is valid for decode.
- id_pc  output  XLEN  PC of the head entry.
- id_instr  output  XLEN  instruction of the head entry; NOP_INSTR when empty.
- id_ready  input  1  decode consumes the head entry this cycle.
- flush  input  1  discard all entries (branch taken / redirect).
- occupancy  output  2  number of valid entries, 0..2.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-low.
- Storage:
  - Two entries, each {pc, instr}.
  - 1-bit write pointer wr_ptr and 1-bit read pointer rd_ptr; both wrap 1->0.
  - 2-bit count.
- Reset (rst=0, asynchronous):
  - count=0, wr_ptr=0, rd_ptr=0.
  - Both entries set to pc=0, instr=NOP_INSTR.
  - Outputs: id_valid=0, id_pc=0, id_instr=NOP_INSTR, if_ready=1, occupancy=0.
  - Applies mid-operation as well: all in-flight entries are lost immediately, without waiting for a clock edge.
- Handshakes:
  - enq = if_valid & if_ready.
  - deq = id_valid & id_ready.
- if_ready = (count != 2).
  - Depends only on registered state; no combinational dependence on id_ready or flush.
- id_valid = (count != 0).
- id_pc = pc of entry[rd_ptr]. id_pc is don't-care when empty but must equal the stored value, never X.
- id_instr = instr of entry[rd_ptr] when count != 0, else NOP_INSTR.
- occupancy = count.
- Latency: an entry enqueued into an empty buffer appears on id_* with id_valid=1 on the next rising edge. There is no same-cycle bypass.
- Per-edge update, in priority order:
  1. flush=1: count=0, wr_ptr=0, rd_ptr=0. Any same-cycle enq is discarded and any same-cycle deq is ignored. Storage contents need not be cleared.
  2. enq only: entry[wr_ptr] <= {if_pc, if_instr}; wr_ptr++; count++.
  3. deq only: rd_ptr++; count--.
  4. enq and deq together (count=1 only, since if_ready=0 at count=2):
     - Write entry[wr_ptr]; increment both pointers; count stays 1.
     - The new entry becomes head on the next edge.
  5. Neither: hold all state.
- Boundaries:
  - Full (count=2): if_ready=0, so if_valid is ignored. A deq takes count to 1, and if_ready returns to 1 on the next cycle.
  - Empty (count=0): id_ready is ignored, and no underflow may occur.
  - if_valid is allowed to drop without being accepted; no state changes in that case.
- Ordering: entries leave strictly in enqueue order across pointer wrap-around.
- No path from any input to any output except through registers, with one exception: id_instr muxes NOP_INSTR on the registered count.

Test Plan:
- Reset and single transfer:
  - Hold rst=0 for 3 cycles, release.
  - Check id_valid=0, id_instr=32'h00000013, if_ready=1, occupancy=0.
  - Enqueue {pc=0x00000000, instr=0x00500093} with id_ready=1.
  - Next cycle: id_valid=1, id_pc=0, id_instr=0x00500093. One cycle later: empty.
- Fill and stall:
  - Hold id_ready=0 and enqueue pc=0x4, 0x8, 0xC on consecutive cycles.
  - Only 0x4 and 0x8 are accepted; occupancy=2; if_ready=0 while 0xC is held.
  - Raise id_ready: outputs 0x4, then 0x8, then 0xC in order, with occupancy never exceeding 2.
- Streaming at count=1:
  - Continuous if_valid=1 and id_ready=1 with PCs 0x10, 0x14, 0x18, 0x1C.
  - id_pc sequence is 0x10, 0x14, 0x18, 0x1C, one per cycle; occupancy stays 1; pointers wrap correctly.
- Flush priority:
  - At occupancy=2 (pc 0x20, 0x24), assert flush together with if_valid=1, pc=0x28.
  - Next cycle: occupancy=0, id_valid=0, id_instr=NOP; 0x28 is not stored.
  - Subsequent enqueue of 0x100 appears as head.
- Asynchronous reset mid-stream:
  - With occupancy=2, drop rst between clock edges.
  - Outputs go to reset values before the next edge; after release, if_ready=1 and occupancy=0.
- Empty dequeue:
  - Hold id_ready=1 with if_valid=0 for 5 cycles after reset.
  - occupancy stays 0, id_valid=0, and no pointer movement occurs (verified by a following enqueue appearing correctly).
